// File: rtl/barrel_pkg.sv
// barrel_pkg: shared definitions for the rotate datapath.
//   WIDTH_DEF  default data width (power of two, >= 2)
//   SHW_DEF    shift-amount width / number of rotate stages for WIDTH_DEF
//   state_t    sequencer state encoding (IDLE, RUN)
//   rotl_pow2  rotate a WIDTH_DEF word left by 2^k; also used by the right-rotator's model
package barrel_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int SHW_DEF   = $clog2(WIDTH_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [WIDTH_DEF-1:0] rotl_pow2(input logic [WIDTH_DEF-1:0] w,
                                                      input int k);
        logic [2*WIDTH_DEF-1:0] dbl;
        dbl = {w, w} << (1 << k);
        return dbl[2*WIDTH_DEF-1:WIDTH_DEF];
    endfunction

endpackage

// File: rtl/barrel_unshifter_rotl_stage.sv
// rotl_stage: one combinational stage of the logarithmic left-rotator.
//   w    in   WIDTH  word to rotate
//   k    in   SHW    stage index; rotate amount is 2^k
//   en   in   1      rotate when high, pass w through when low
//   y    out  WIDTH  result
module rotl_stage #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] w,
    input  logic [SHW-1:0]   k,
    input  logic             en,
    output logic [WIDTH-1:0] y
);

    // Shifting the doubled word left and keeping the upper half is a rotate:
    // the bits pushed out of the top copy are refilled from the lower copy.
    logic [2*WIDTH-1:0] dbl;

    always_comb begin
        dbl = {w, w} << (1 << k);
        y   = en ? dbl[2*WIDTH-1:WIDTH] : w;
    end

endmodule

// File: rtl/barrel_unshifter.sv
// barrel_unshifter: multi-cycle left-rotator, one power-of-two stage per clock.
// Undoes the upstream right rotation: rotl(rotr(x, s), s) == x.
//   clk       in   1      rising-edge clock
//   clear     in   1      asynchronous active-high reset
//   start     in   1      request, sampled while busy==0
//   data_in   in   WIDTH  operand, captured with start
//   shift     in   SHW    left-rotate amount, captured with start
//   data_out  out  WIDTH  result, updated only on the completion edge
//   busy      out  1      operation in progress, start ignored
//   done      out  1      one-cycle pulse when data_out takes a new result
module barrel_unshifter
    import barrel_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shift,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    localparam logic [SHW-1:0] K_ONE  = SHW'(1);
    localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [SHW-1:0]   sh_q,    sh_d;
    logic [SHW-1:0]   k_q,     k_d;
    logic [WIDTH-1:0] dout_d;
    logic             busy_d, done_d;

    // A single stage is time-shared: stage 0 on the fresh operand at accept,
    // then stage k on the work register while running.
    logic [WIDTH-1:0] stg_w, stg_y;
    logic [SHW-1:0]   stg_k;
    logic             stg_en;

    rotl_stage #(.WIDTH(WIDTH)) u_stage (
        .w  (stg_w),
        .k  (stg_k),
        .en (stg_en),
        .y  (stg_y)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            work_q   <= '0;
            sh_q     <= '0;
            k_q      <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            sh_q     <= sh_d;
            k_q      <= k_d;
            data_out <= dout_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        sh_d    = sh_q;
        k_d     = k_q;
        dout_d  = data_out;
        busy_d  = busy;
        done_d  = 1'b0;
        stg_w   = data_in;
        stg_k   = '0;
        stg_en  = shift[0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d   = shift;
                    work_d = stg_y;
                    if (SHW == 1) begin
                        // Single-stage build: stage 0 is also the last stage.
                        dout_d = stg_y;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        k_d     = K_ONE;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                stg_w  = work_q;
                stg_k  = k_q;
                stg_en = sh_q[k_q];
                work_d = stg_y;
                k_d    = k_q + K_ONE;
                if (k_q == K_LAST) begin
                    dout_d  = stg_y;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    k_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_barrel_unshifter.sv
module tb_barrel_unshifter;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic [7:0] data_in;
    logic [2:0] shift;
    logic [7:0] data_out;
    logic       busy, done;

    logic       start2;
    logic [1:0] din2;
    logic       sh2;
    logic [1:0] dout2;
    logic       busy2, done2;

    int checks   = 0;
    int failures = 0;
    logic [7:0] last_out;

    always #5 clk = ~clk;

    barrel_unshifter #(.WIDTH(8)) dut (
        .clk(clk), .clear(clear), .start(start), .data_in(data_in), .shift(shift),
        .data_out(data_out), .busy(busy), .done(done)
    );

    barrel_unshifter #(.WIDTH(2)) dut2 (
        .clk(clk), .clear(clear), .start(start2), .data_in(din2), .shift(sh2),
        .data_out(dout2), .busy(busy2), .done(done2)
    );

    // Reference rotations on plain integers.
    function automatic logic [7:0] rotl8(input int x, input int s);
        int r;
        r = ((x << s) | (x >> (8 - s))) & 255;
        return r[7:0];
    endfunction

    function automatic logic [7:0] rotr8(input int x, input int s);
        int r;
        r = ((x >> s) | (x << (8 - s))) & 255;
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation on the 8-bit DUT with cycle-by-cycle handshake checks.
    task automatic run_op(input logic [7:0] d, input logic [2:0] s, input string tag);
        logic [7:0] exp;
        exp = rotl8(int'(d), int'(s));
        @(negedge clk);
        start = 1'b1; data_in = d; shift = s;
        @(negedge clk);
        start = 1'b0; data_in = 8'($urandom); shift = 3'($urandom);
        chk({tag, ".c1.busy"}, busy, 1);
        chk({tag, ".c1.done"}, done, 0);
        chk({tag, ".c1.hold"}, data_out, last_out);
        @(negedge clk);
        chk({tag, ".c2.busy"}, busy, 1);
        chk({tag, ".c2.done"}, done, 0);
        chk({tag, ".c2.hold"}, data_out, last_out);
        @(negedge clk);
        chk({tag, ".c3.done"}, done, 1);
        chk({tag, ".c3.busy"}, busy, 0);
        chk({tag, ".c3.data"}, data_out, exp);
        last_out = exp;
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; data_in = '0; shift = '0;
        start2 = 1'b0; din2 = '0; sh2 = 1'b0;
        last_out = '0;
        #12;
        chk("rst.data", data_out, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.w2.data", dout2, 0);
        @(negedge clk);
        clear = 1'b0;

        // Directed operands.
        run_op(8'hB4, 3'd3, "b4s3");
        chk("b4s3.value", data_out, 8'hA5);
        run_op(8'h01, 3'd7, "01s7");
        chk("01s7.value", data_out, 8'h80);
        run_op(8'h5A, 3'd0, "5as0");
        chk("5as0.value", data_out, 8'h5A);

        // Back-to-back: start held high through the op; second operand offered in the done cycle.
        @(negedge clk);
        start = 1'b1; data_in = 8'h3C; shift = 3'd2;
        @(negedge clk);
        data_in = 8'hEE; shift = 3'd7;
        chk("b2b.c1.busy", busy, 1);
        @(negedge clk);
        chk("b2b.c2.busy", busy, 1);
        chk("b2b.c2.done", done, 0);
        @(negedge clk);
        chk("b2b.first.done", done, 1);
        chk("b2b.first.data", data_out, 8'hF0);
        data_in = 8'h81; shift = 3'd1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b.second.c1.busy", busy, 1);
        chk("b2b.second.c1.done", done, 0);
        chk("b2b.second.c1.hold", data_out, 8'hF0);
        @(negedge clk);
        start = 1'b1;
        chk("b2b.second.c2.done", done, 0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b.second.done", done, 1);
        chk("b2b.second.data", data_out, 8'h03);
        @(negedge clk);
        chk("b2b.pulse_one_cycle", done, 0);
        last_out = 8'h03;

        // Clear in the middle of an operation.
        @(negedge clk);
        start = 1'b1; data_in = 8'hFF; shift = 3'd5;
        @(negedge clk);
        start = 1'b0;
        chk("abort.c1.busy", busy, 1);
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("abort.data", data_out, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort.no_done", done, 0);
        end
        last_out = '0;
        run_op(8'h12, 3'd4, "after_clear");
        chk("after_clear.value", data_out, 8'h21);

        // Random operands against the integer model.
        for (int i = 0; i < 40; i++)
            run_op(8'($urandom), 3'($urandom_range(0, 7)), "rand");

        // Round trip through a right rotation by the same amount.
        for (int d = 0; d < 256; d++)
            for (int s = 0; s < 8; s++) begin
                run_op(rotr8(d, s), 3'(s), "rt");
                chk("rt.orig", data_out, d);
            end

        // Single-stage build.
        @(negedge clk);
        start2 = 1'b1; din2 = 2'b01; sh2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("w2.done", done2, 1);
        chk("w2.busy", busy2, 0);
        chk("w2.data", dout2, 2'b10);
        @(negedge clk);
        chk("w2.pulse", done2, 0);
        chk("w2.hold", dout2, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
